load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Accepts load/store requests from the MIPS datapath (byte/half/word, signed/unsigned loads) and drives word-wide address, write-data, write-strobe and read-strobe toward the data memory.
- The data memory is word-only: combinational read, write on posedge. Sub-word stores are therefore done as read-modify-write.
- Returns extended load data, and flags misaligned or illegal requests.

---
 rtl/load_store_unit_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit_lane.sv | 46 ++++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used at request accept.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Reserved size is treated as an alignment failure so a single test covers all encodings.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lsb[0];
            SIZE_WORD: bad = |lsb;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// master: datapath plus memory environment; slave: the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_write;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       mem_data_read;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_read,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_data_write, mem_write, mem_read
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_read,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_data_write, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit_lane.sv
// Byte-lane logic shared by load extraction (with sign/zero extension)
// and the read-modify-write merge of sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]         bsh;
    logic [4:0]         hsh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] b_ext;
    logic signed [31:0] h_ext;

    always_comb begin
        bsh   = {addr_i, 3'b000};
        hsh   = {addr_i[1], 4'b0000};
        b_s   = $signed(8'(word_i >> bsh));
        h_s   = $signed(16'(word_i >> hsh));
        b_ext = b_s;
        h_ext = h_s;
        load_o  = word_i;
        merge_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                load_o  = uns_i ? {24'h0, b_s} : b_ext;
                merge_o = (word_i & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata_i[7:0]} << bsh);
            end
            SIZE_HALF: begin
                load_o  = uns_i ? {16'h0, h_s} : h_ext;
                merge_o = (word_i & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata_i[15:0]} << hsh);
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit toward a word-only data memory; sub-word stores use read-modify-write.
// Optional address range check enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    lsu_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              bounds_err;
    logic              req_err;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merge;

    assign bounds_err = BOUNDS_EN && ({2'b00, bus.req_addr[ADDR_W-1:2]} >= MEM_LIMIT);
    assign req_err    = size_misaligned(bus.req_size, bus.req_addr[1:0]) || bounds_err;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_write && bus.req_size == SIZE_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rdata_d = bus.mem_data_read;
                state_d = write_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Control and the visible address are cleared; data registers are only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    lsu_lane u_lane (
        .word_i  (rdata_q),
        .addr_i  (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.resp_valid     = (state_q == RESP);
    assign bus.resp_error     = (state_q == RESP) && err_q;
    assign bus.resp_rdata     = (state_q == RESP && !write_q && !err_q) ? lane_load : 32'h0;
    assign bus.mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_read       = (state_q == RD);
    // Gate the strobe with reset so an access abandoned by reset never commits.
    assign bus.mem_write      = (state_q == WR) && reset;
    assign bus.mem_data_write = (state_q == WR) ? lane_merge : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset/bounds
// sequences and random traffic against a byte-array reference model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.MEM_WORDS(256), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write on posedge.
    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_val = 32'h0;
    assign bus.mem_data_read = mem[bus.mem_address[9:2]];
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_data_write;
    end

    logic [7:0] ref_b [0:1023];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eer;
        int          elat;
        int          enwr;
        int          enrd;
        logic [31:0] ewdata;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = 8'(idx); poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwr, output int nrd, output logic [31:0] wr_data,
                          output logic [31:0] wr_addr, output logic [31:0] rd_addr);
        rd = 32'h0; er = 1'b0; lat = 0; nwr = 0; nrd = 0;
        wr_data = 32'h0; wr_addr = 32'h0; rd_addr = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.mem_read) begin nrd++; rd_addr = bus.mem_address; end
            if (bus.mem_write) begin nwr++; wr_data = bus.mem_data_write; wr_addr = bus.mem_address; end
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_error;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("resp_pulse_drop", {31'h0, bus.resp_valid}, 32'h0);
        chk("ready_after_resp", {31'h0, bus.req_ready}, 32'h1);
    endtask

    // Reference: memory as a byte array; loads assemble little-endian lanes, stores overwrite n bytes.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] erd, output logic eer, output int elat,
                         output int enwr, output int enrd);
        int n;
        logic [31:0] v;
        logic [31:0] tmp;
        n = 1 << sz;
        eer = (sz == 2'b11) || ((a % n) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        if ((a / 4) >= 256) eer = 1'b1;
`endif
        erd = 32'h0; enwr = 0; enrd = 0; elat = 1;
        if (eer) begin
            elat = 1;
        end else if (!w) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
            if (!u && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            erd = v; elat = 2; enrd = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                tmp = wd >> (8 * i);
                ref_b[int'(a) + i] = tmp[7:0];
            end
            elat = (n == 4) ? 2 : 3; enwr = 1; enrd = (n == 4) ? 0 : 1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wdat, waddr, raddr, erd, wv;
        logic        er, eer;
        int          lat, nwr, nrd, elat, enwr, enrd, wcnt;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_error", {31'h0, bus.resp_error}, 32'h0);
        chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
        chk("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_data_write", bus.mem_data_write, 32'h0);
        reset = 1'b1;

        poke(0, 32'h8899AABB);
        poke(1, 32'h11223344);

        //          w     sz     u     addr   wdata         rdata         err  lat nwr nrd wdata-out
        tbl[0]  = '{1'b0, 2'b00, 1'b0, 32'h1, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 1, 32'h0};
        tbl[1]  = '{1'b0, 2'b01, 1'b1, 32'h2, 32'h0,        32'h00008899, 1'b0, 2, 0, 1, 32'h0};
        tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h2, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, 1, 32'h0};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h6, 32'h000000EE, 32'h0,        1'b0, 3, 1, 1, 32'h11EE3344};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h11EE3344, 1'b0, 2, 0, 1, 32'h0};
        tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1, 32'h0};
        tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h3, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h5, 32'h0000ABCD, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[10] = '{1'b0, 2'b00, 1'b1, 32'h0, 32'h0,        32'h000000BB, 1'b0, 2, 0, 1, 32'h0};
        tbl[11] = '{1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF1234, 32'h0,        1'b0, 3, 1, 1, 32'h1234AABB};
        tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h1234AABB, 1'b0, 2, 0, 1, 32'h0};
        tbl[13] = '{1'b0, 2'b00, 1'b0, 32'h3, 32'h0,        32'h00000012, 1'b0, 2, 0, 1, 32'h0};

        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                   rd, er, lat, nwr, nrd, wdat, waddr, raddr);
            chk($sformatf("v%0d rdata", i), rd, tbl[i].erd);
            chk($sformatf("v%0d error", i), {31'h0, er}, {31'h0, tbl[i].eer});
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].elat));
            chk($sformatf("v%0d mem_write_count", i), 32'(nwr), 32'(tbl[i].enwr));
            chk($sformatf("v%0d mem_read_count", i), 32'(nrd), 32'(tbl[i].enrd));
            if (tbl[i].enwr > 0) begin
                chk($sformatf("v%0d mem_data_write", i), wdat, tbl[i].ewdata);
                chk($sformatf("v%0d mem_address_wr", i), waddr, {tbl[i].a[31:2], 2'b00});
            end
            if (tbl[i].enrd > 0) chk($sformatf("v%0d mem_address_rd", i), raddr, {tbl[i].a[31:2], 2'b00});
        end

        // Reset during the read phase of a byte store abandons it.
        poke(4, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h11; bus.req_wdata = 32'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstmid_in_rd", {31'h0, bus.mem_read}, 32'h1);
        reset = 1'b0;
        wcnt = 0;
        @(negedge clk);
        if (bus.mem_write) wcnt++;
        chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_write) wcnt++;
        end
        chk("rstmid_no_write", 32'(wcnt), 32'h0);
        chk("rstmid_mem_unchanged", mem[4], 32'hCAFEF00D);

        // Address beyond MEM_WORDS.
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat, nwr, nrd, wdat, waddr, raddr);
`ifdef LSU_BOUNDS_CHECK_EN
        chk("oob_error", {31'h0, er}, 32'h1);
        chk("oob_no_read", 32'(nrd), 32'h0);
`else
        chk("oob_error", {31'h0, er}, 32'h0);
        chk("oob_addr_passthru", raddr, 32'h400);
        chk("oob_rdata_alias", rd, 32'h1234AABB);
`endif

        // Random traffic over words 0..15 against the byte model.
        for (int i = 0; i < 16; i++) begin
            wv = $urandom;
            poke(i, wv);
            for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'(wv >> (8 * k));
        end
        for (int t = 0; t < 300; t++) begin
            logic        rw, ru;
            logic [1:0]  rsz;
            logic [31:0] ra, rwd;
            rw  = 1'($urandom_range(0, 1));
            ru  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 63));
            rwd = $urandom;
            model(rw, rsz, ru, ra, rwd, erd, eer, elat, enwr, enrd);
            do_req(rw, rsz, ru, ra, rwd, rd, er, lat, nwr, nrd, wdat, waddr, raddr);
            chk($sformatf("r%0d rdata", t), rd, erd);
            chk($sformatf("r%0d error", t), {31'h0, er}, {31'h0, eer});
            chk($sformatf("r%0d latency", t), 32'(lat), 32'(elat));
            chk($sformatf("r%0d mem_write_count", t), 32'(nwr), 32'(enwr));
            chk($sformatf("r%0d mem_read_count", t), 32'(nrd), 32'(enrd));
        end
        for (int i = 0; i < 16; i++) begin
            model(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, erd, eer, elat, enwr, enrd);
            do_req(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, rd, er, lat, nwr, nrd, wdat, waddr, raddr);
            chk($sformatf("sweep%0d word", i), rd, erd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
